// File: rtl/dabble_bcd_encoder.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Results and overflow stay stable between conversions; done pulses on each completion.
module dabble_bcd_encoder #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 4 * DIGITS;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] src_q, src_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic [AW-1:0]    bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [AW-1:0]    adj;
  logic [AW-1:0]    acc_sh;
  logic             out_bit;

  always_comb begin
    // Digits are corrected independently; no carry crosses a digit boundary.
    adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    acc_sh  = {adj[AW-2:0], src_q[WIDTH-1]};
    out_bit = adj[AW-1];

    state_d  = state_q;
    src_d    = src_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d    = bin;
          acc_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_SHIFT;
        end
      end
      default: begin
        src_d    = src_q << 1;
        acc_d    = acc_sh;
        sticky_d = sticky_q | out_bit;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          bcd_d   = acc_sh;
          ovf_d   = sticky_q | out_bit;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy     = (state_q == S_SHIFT);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_dabble_bcd_encoder.sv
// Self-checking bench: default-parameter converter plus a 2-digit instance,
// checked against a divide-by-ten decimal reference model.
module tb_dabble_bcd_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  bin = '0;
  logic        busy, done, overflow;
  logic [11:0] bcd;

  logic        start2 = 1'b0;
  logic [7:0]  bin2 = '0;
  logic        busy2, done2, overflow2;
  logic [7:0]  bcd2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dabble_bcd_encoder #(.WIDTH(8), .DIGITS(3)) u_dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
  );

  dabble_bcd_encoder #(.WIDTH(8), .DIGITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(overflow2)
  );

  function automatic logic [47:0] bcd_model(input int v, input int nd);
    logic [47:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic ovf_model(input int v, input int nd);
    int p;
    p = 1;
    for (int i = 0; i < nd; i++) p = p * 10;
    return (v >= p);
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full handshake on the 3-digit instance: busy length, held result, final value.
  task automatic conv8(input int v, input string tag);
    logic [11:0] prev;
    logic        held;
    int          cyc;
    @(negedge clk);
    prev  = bcd;
    bin   = 8'(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    held  = 1'b1;
    cyc   = 0;
    while (busy && cyc < 30) begin
      if (bcd !== prev || done !== 1'b0) held = 1'b0;
      cyc++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 48'(cyc), 48'(8));
    check({tag, " held"}, 48'(held), 48'(1));
    check({tag, " done"}, 48'(done), 48'(1));
    check({tag, " bcd"}, 48'(bcd), bcd_model(v, 3));
    check({tag, " ovf"}, 48'(overflow), 48'(ovf_model(v, 3)));
    @(negedge clk);
    check({tag, " done_pulse"}, 48'(done), 48'(0));
  endtask

  task automatic conv2(input int v, input string tag);
    int cyc;
    @(negedge clk);
    bin2   = 8'(v);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 30) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, " done"}, 48'(done2), 48'(1));
    check({tag, " bcd"}, 48'(bcd2), bcd_model(v, 2));
    check({tag, " ovf"}, 48'(overflow2), 48'(ovf_model(v, 2)));
  endtask

  initial begin
    int v, cyc, ndone;
    logic [11:0] cap;

    // Reset state
    #1;
    check("rst busy", 48'(busy), 48'(0));
    check("rst done", 48'(done), 48'(0));
    check("rst bcd", 48'(bcd), 48'(0));
    check("rst ovf", 48'(overflow), 48'(0));
    check("rst bcd2", 48'(bcd2), 48'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed values
    conv8(0,   "zero");
    conv8(255, "v255");
    conv8(99,  "v99");
    conv8(128, "v128");

    // Random values
    for (int i = 0; i < 12; i++) begin
      v = $urandom_range(0, 255);
      conv8(v, "rand8");
    end

    // start/bin changes during a conversion are ignored
    @(negedge clk);
    bin = 8'd52; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bin = 8'd71; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; cap = '0;
    for (int i = 0; i < 25; i++) begin
      if (done) begin ndone++; cap = bcd; end
      @(negedge clk);
    end
    check("ignore bcd", 48'(cap), 48'h052);
    check("ignore ndone", 48'(ndone), 48'(1));

    // Two-digit instance, overflow boundary
    conv2(100, "d2 v100");
    conv2(71,  "d2 v71");
    conv2(99,  "d2 v99");
    for (int i = 0; i < 6; i++) begin
      v = $urandom_range(0, 255);
      conv2(v, "d2 rand");
    end

    // Exhaustive sweep with start held high
    @(negedge clk);
    bin = 8'd0; start = 1'b1;
    for (int n = 0; n < 256; n++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!done && cyc < 30);
      if (!done) begin
        check("sweep timeout", 48'(done), 48'(1));
        break;
      end
      bin = 8'(n + 1);
      check("sweep bcd", 48'(bcd), bcd_model(n, 3));
      check("sweep ovf", 48'(overflow), 48'(0));
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Asynchronous reset mid-conversion
    conv8(37, "pre_rst");
    @(negedge clk);
    bin = 8'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst busy", 48'(busy), 48'(0));
    check("arst done", 48'(done), 48'(0));
    check("arst bcd", 48'(bcd), 48'(0));
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("arst no_done", 48'(ndone), 48'(0));
    conv8(200, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
